// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared state encoding, mode codes and period constants for the waveform sequencer
package wave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SAWUP = 2'b00;
  localparam logic [1:0] MODE_SAWDN = 2'b01;
  localparam logic [1:0] MODE_TRI   = 2'b10;
  localparam logic [1:0] MODE_SQR   = 2'b11;

  localparam int SAW_PERIOD = 16;
  localparam int TRI_PERIOD = 30;

endpackage

// File: rtl/wave_counter.sv
// rtl/wave_counter.sv - WIDTH-bit up/down counter with synchronous clear and enable
module wave_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;

  // Wraps naturally at both ends; the sequencer never steps down from zero.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_value <= '0;
    end else if (i_en) begin
      if (i_up) r_value <= r_value + 1'b1;
      else      r_value <= r_value - 1'b1;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - run-control FSM, period bookkeeping and sample mapping around wave_counter
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic [3:0]       i_cycles,
  output logic [WIDTH-1:0] o_wave,
  output logic             o_busy,
  output logic             o_done
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_mode;
  logic [3:0]       r_cycles;
  logic [3:0]       r_left;
  logic             r_dir_up;

  logic [WIDTH-1:0] w_cnt;
  logic             w_cnt_clear;
  logic             w_cnt_en;
  logic             w_cnt_up;
  logic             w_is_tri;
  logic             w_at_top;
  logic             w_at_one;
  logic             w_period_end;
  logic             w_last_period;
  logic [WIDTH-1:0] w_sample;

  assign w_is_tri      = (r_mode == MODE_TRI);
  assign w_at_top      = (w_cnt == {WIDTH{1'b1}});
  assign w_at_one      = (w_cnt == WIDTH'(1));
  assign w_period_end  = w_is_tri ? (w_at_one && !r_dir_up) : w_at_top;
  assign w_last_period = (r_cycles != 4'd0) && (r_left == 4'd1);

  // Triangle turns around at the top on the same step that reaches it registered as dir.
  assign w_cnt_up    = !w_is_tri || (r_dir_up && !w_at_top);
  assign w_cnt_en    = (r_state == RUN);
  assign w_cnt_clear = i_clear || (r_state != RUN) || (w_next != RUN);

  wave_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .i_clock (i_clock),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .i_up    (w_cnt_up),
    .o_value (w_cnt)
  );

  always_ff @(posedge i_clock) begin
    if (i_clear) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_start) w_next = RUN;
      RUN: begin
        if (i_stop)                              w_next = IDLE;
        else if (w_period_end && w_last_period)  w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_mode   <= MODE_SAWUP;
      r_cycles <= 4'd0;
      r_left   <= 4'd0;
      r_dir_up <= 1'b1;
    end else if (r_state == IDLE && i_start) begin
      r_mode   <= i_mode;
      r_cycles <= i_cycles;
      r_left   <= i_cycles;
      r_dir_up <= 1'b1;
    end else if (r_state == RUN) begin
      if (w_is_tri) begin
        if (w_at_top)                   r_dir_up <= 1'b0;
        else if (w_at_one && !r_dir_up) r_dir_up <= 1'b1;
      end
      // Continuous runs (cycles 0) leave left untouched.
      if (w_period_end && r_cycles != 4'd0 && r_left != 4'd1) r_left <= r_left - 4'd1;
    end
  end

  always_comb begin
    w_sample = '0;
    case (r_mode)
      MODE_SAWUP: w_sample = w_cnt;
      MODE_SAWDN: w_sample = ~w_cnt;
      MODE_TRI:   w_sample = w_cnt;
      MODE_SQR:   w_sample = {WIDTH{~w_cnt[WIDTH-1]}};
      default:    w_sample = '0;
    endcase
  end

  assign o_wave = (r_state == RUN) ? w_sample : '0;
  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

Controller for the waveform generator's 4-bit counter datapath. It accepts a start request and latches a mode and a period count. It then sequences an internal 4-bit counter to produce sawtooth-up, sawtooth-down, triangle or square samples on a 4-bit output. It runs for a programmed number of waveform periods, or continuously until stopped, and signals completion with a one-cycle done pulse.

## Interface
- WIDTH, 4, sample and counter width; all values below assume 4.
- clock  in  1  sole clock, rising-edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort a run; sampled only in RUN.
- mode  in  2  00 saw-up, 01 saw-down, 10 triangle, 11 square; latched on accepted start.
- cycles  in  4  number of periods to emit; 0 means continuous; latched on accepted start.
- wave  out  4  current sample; 0 whenever not in RUN.
- busy  out  1  high exactly while in RUN.
- done  out  1  one-cycle pulse in DONE state.

## Operation
- States: IDLE, RUN, DONE.
- Registers: cnt[3:0], dir (up/down, triangle only), mode_r, cycles_r, left[3:0].
- IDLE, start=1: at the edge, latch mode_r and cycles_r, set left=cycles, cnt=0, dir=up, and go to RUN.
- Start/stop precedence: start while in RUN or DONE is ignored. stop while in IDLE is ignored. If start and stop are both high in IDLE, start wins.
- RUN, stop=1: go to IDLE at the next edge and set cnt=0. No done pulse. stop has priority over every other RUN transition.
- RUN advance, saw-up, saw-down and square: cnt advances by 1 per cycle and wraps 15→0. Period length is 16; the period's last sample is at cnt==15.
- RUN advance, triangle: the sequence is 0,1,…,15,14,…,1, then repeats from 0. Period length is 30.
  - dir flips to down when cnt reaches 15.
  - dir flips to up when cnt==1 and dir is down, as cnt steps to 0.
  - The period's last sample is cnt==1 with dir down.
- Sample mapping from cnt:
  - saw-up: wave=cnt.
  - saw-down: wave=15−cnt.
  - triangle: wave=cnt.
  - square: wave=4'hF if cnt<8, else 0.
- Period-end handling:
  - cycles_r==0: continue forever; left is not modified.
  - cycles_r!=0 and left==1: go to DONE.
  - cycles_r!=0 and left!=1: decrement left and continue with the next period.
- DONE: done=1, busy=0, wave=0. Return to IDLE unconditionally at the next edge.
- clear: at any edge with clear=1, set state=IDLE, cnt=0, dir=up, left=0, mode_r=0, cycles_r=0. clear overrides start and stop.

## Timing
- Reset values: wave=0, busy=0, done=0.
- Start latency: start is accepted at edge k. busy and wave=f(0) are visible from edge k until edge k+1.
- Outputs depend only on registered state; there is no combinational path from any input to wave, busy or done.
- Run length: a run of N periods holds busy high for exactly 16·N cycles (saw/square) or 30·N cycles (triangle).
- Completion: done is high for the single cycle after the last sample. A new start is accepted no earlier than the cycle after done, in IDLE.
- Mid-run changes: changes on mode or cycles during RUN have no effect.
- Mid-run clear: takes effect at the next edge. busy and wave are 0 after it.

## Structure
- Shared package wave_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - mode constants: MODE_SAWUP, MODE_SAWDN, MODE_TRI, MODE_SQR.
  - the triangle period constant, 30.
- Sub-module wave_counter: WIDTH-bit up/down counter with synchronous clear, enable and dir inputs and value output. wave_sequencer owns the FSM, the period bookkeeping and the sample mapping.

## Test plan
- Reset, then start with mode=00, cycles=1:
  - busy=1 for 16 cycles; wave = 0,1,…,15.
  - done=1 for one cycle; busy=0, wave=0.
- mode=10, cycles=2:
  - wave = 0..15,14..1 twice; 60 busy cycles.
  - Single done pulse, then IDLE.
- mode=11, cycles=0:
  - wave = F×8, 0×8, repeating for 100 cycles with no done.
  - stop at cycle 37: next cycle busy=0, wave=0, done never asserted.
- mode=01, cycles=3:
  - Assert clear at cycle 20 while busy.
  - Next cycle: busy=0, wave=0, done=0.
  - A fresh start after that restarts at wave=15.
- During a mode=00, cycles=1 run, pulse start and change mode to 11 at cycle 5:
  - wave continues 6,7,…,15 unchanged; exactly one done.
  - start held high through DONE is accepted only in the following IDLE cycle.
- In IDLE, start=1 and stop=1 on the same edge: the run begins (busy=1). stop alone in IDLE: no state change.
